util_sync_debounce: RTL and testbench

//  Multi-channel synchronizer, debouncer and edge detector for asynchronous

---
 rtl/util_sync_debounce.sv | 109 ++++++++++
 tb/tb_util_sync_debounce.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/util_sync_debounce.sv
// util_sync_debounce
//   Multi-channel synchronizer, debouncer and edge detector for asynchronous
//   pin-level inputs. Each channel runs through a STAGES-deep synchronizer,
//   then a stability filter that updates q only after DEBOUNCE consecutive
//   synced cycles that differ from q. Registered one-cycle rise/fall pulses
//   are produced alongside q. Sticky event flags are kept per channel, with a
//   per-bit clear and an OR-reduced interrupt.
// Ports
//   clk      in   1      system clock, all state on posedge
//   res_n    in   1      asynchronous active-low reset
//   d        in   WIDTH  raw asynchronous inputs
//   q        out  WIDTH  synchronized, debounced level
//   rise     out  WIDTH  one-cycle pulse on the first cycle q[i] shows 1
//   fall     out  WIDTH  one-cycle pulse on the first cycle q[i] shows 0
//   evt      out  WIDTH  sticky event flags (0=rise, 1=fall, 2=both edges)
//   evt_clr  in   WIDTH  per-bit clear of evt; a coincident set wins
//   irq      out  1      OR of evt, registered together with evt
module util_sync_debounce #(
  parameter int             WIDTH     = 8,
  parameter int             STAGES    = 2,
  parameter int             DEBOUNCE  = 4,
  parameter int             EDGE_MODE = 0,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic             clk,
  input  logic             res_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic [WIDTH-1:0] evt,
  input  logic [WIDTH-1:0] evt_clr,
  output logic             irq
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [STAGES-1:0][WIDTH-1:0] sync_r;
  logic [WIDTH-1:0]             s;
  logic [WIDTH-1:0][CW-1:0]     cnt;
  logic [WIDTH-1:0][CW-1:0]     cnt_next;
  logic [WIDTH-1:0]             q_next;
  logic [WIDTH-1:0]             rise_next;
  logic [WIDTH-1:0]             fall_next;
  logic [WIDTH-1:0]             evt_set;
  logic [WIDTH-1:0]             evt_next;

  // Synchronizer chain: nothing but flops, index 0 samples the pin.
  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      sync_r <= {STAGES{RESET_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign s = sync_r[STAGES-1];

  // Stability filter: count cycles where s disagrees with q; any agreement
  // restarts the count, the DEBOUNCE-th disagreeing cycle commits s to q.
  always_comb begin
    q_next   = q;
    cnt_next = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s[i] != q[i]) begin
        if (cnt[i] == CW'(DEBOUNCE - 1)) begin
          q_next[i] = s[i];
        end else begin
          cnt_next[i] = cnt[i] + CW'(1);
        end
      end
    end
  end

  // Pulses are derived from q's next state so they line up with the cycle
  // in which q first shows the new value.
  assign rise_next = q_next & ~q;
  assign fall_next = ~q_next & q;

  always_comb begin
    case (EDGE_MODE)
      0:       evt_set = rise_next;
      1:       evt_set = fall_next;
      default: evt_set = rise_next | fall_next;
    endcase
  end

  // Clear first, then set, so a set in the same cycle wins.
  assign evt_next = (evt & ~evt_clr) | evt_set;

  always_ff @(posedge clk or negedge res_n) begin
    if (!res_n) begin
      q    <= RESET_VAL;
      cnt  <= '0;
      rise <= '0;
      fall <= '0;
      evt  <= '0;
      irq  <= 1'b0;
    end else begin
      q    <= q_next;
      cnt  <= cnt_next;
      rise <= rise_next;
      fall <= fall_next;
      evt  <= evt_next;
      irq  <= |evt_next;
    end
  end

endmodule

// File: tb/tb_util_sync_debounce.sv
// tb_util_sync_debounce
//   Scoreboard bench for util_sync_debounce. Two instances share all inputs:
//   one with EDGE_MODE=0 (rise events) and one with EDGE_MODE=2 (both edges).
//   A reference model predicts outputs per clock edge from a history of
//   sampled inputs and a sliding window of synced values; a monitor compares.
module tb_util_sync_debounce;

  localparam int W  = 8;
  localparam int ST = 2;
  localparam int DB = 4;

  logic         clk = 1'b0;
  logic         res_n = 1'b0;
  logic [W-1:0] d = '0;
  logic [W-1:0] evt_clr = '0;

  logic [W-1:0] q0, rise0, fall0, evt0;
  logic         irq0;
  logic [W-1:0] q2, rise2, fall2, evt2;
  logic         irq2;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  util_sync_debounce #(
    .WIDTH(W), .STAGES(ST), .DEBOUNCE(DB), .EDGE_MODE(0), .RESET_VAL(8'h00)
  ) dut0 (
    .clk(clk), .res_n(res_n), .d(d), .q(q0), .rise(rise0), .fall(fall0),
    .evt(evt0), .evt_clr(evt_clr), .irq(irq0)
  );

  util_sync_debounce #(
    .WIDTH(W), .STAGES(ST), .DEBOUNCE(DB), .EDGE_MODE(2), .RESET_VAL(8'h00)
  ) dut2 (
    .clk(clk), .res_n(res_n), .d(d), .q(q2), .rise(rise2), .fall(fall2),
    .evt(evt2), .evt_clr(evt_clr), .irq(irq2)
  );

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] rise;
    logic [W-1:0] fall;
    logic [W-1:0] e0;
    logic         i0;
    logic [W-1:0] e2;
    logic         i2;
  } exp_t;

  exp_t exp_q[$];

  // Reference model state
  logic [W-1:0] dhist[$];   // inputs sampled at earlier edges, front = synced value
  logic [W-1:0] win[$];     // last DB synced values seen by the filter
  logic [W-1:0] mq  = '0;
  logic [W-1:0] me0 = '0;
  logic [W-1:0] me2 = '0;

  always @(posedge clk) begin
    exp_t         e;
    logic [W-1:0] sv, and_all, or_all, nq, r, f;
    if (!res_n) begin
      dhist.delete();
      for (int k = 0; k < ST; k++) dhist.push_back(8'h00);
      win.delete();
      mq  = '0;
      me0 = '0;
      me2 = '0;
      r   = '0;
      f   = '0;
    end else begin
      sv = dhist.pop_front();
      dhist.push_back(d);
      win.push_back(sv);
      if (win.size() > DB) void'(win.pop_front());
      and_all = '1;
      or_all  = '0;
      foreach (win[k]) begin
        and_all &= win[k];
        or_all  |= win[k];
      end
      nq = mq;
      if (win.size() == DB) begin
        nq = (mq | and_all) & or_all;  // all-ones window -> 1, all-zeros -> 0
      end
      r   = nq & ~mq;
      f   = ~nq & mq;
      me0 = (me0 & ~evt_clr) | r;
      me2 = (me2 & ~evt_clr) | r | f;
      mq  = nq;
    end
    e.q    = mq;
    e.rise = r;
    e.fall = f;
    e.e0   = me0;
    e.i0   = |me0;
    e.e2   = me2;
    e.i2   = |me2;
    exp_q.push_back(e);
  end

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: outputs are valid every cycle; compare on the falling edge.
  always @(negedge clk) begin
    exp_t e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("q0", q0, e.q);
      chk("rise0", rise0, e.rise);
      chk("fall0", fall0, e.fall);
      chk("evt0", evt0, e.e0);
      chk("irq0", {7'b0, irq0}, {7'b0, e.i0});
      chk("q2", q2, e.q);
      chk("rise2", rise2, e.rise);
      chk("fall2", fall2, e.fall);
      chk("evt2", evt2, e.e2);
      chk("irq2", {7'b0, irq2}, {7'b0, e.i2});
      chk("rise_fall_overlap", rise0 & fall0, 8'h00);
    end
  end

  // One call = the values held for the next rising edge.
  task automatic cyc(input logic [W-1:0] dv, input logic [W-1:0] clrv, input logic rn);
    @(negedge clk);
    #1;
    d       = dv;
    evt_clr = clrv;
    res_n   = rn;
  endtask

  initial begin
    logic [W-1:0] dr;
    // reset with inputs high, then release
    repeat (4)  cyc(8'hFF, 8'h00, 1'b0);
    repeat (10) cyc(8'hFF, 8'h00, 1'b1);
    repeat (10) cyc(8'h00, 8'hFF, 1'b1);
    // single-channel step
    repeat (10) cyc(8'h01, 8'h00, 1'b1);
    // glitch of 3 cycles on channel 1, then a qualifying 4+ cycle pulse
    repeat (3)  cyc(8'h03, 8'h00, 1'b1);
    repeat (6)  cyc(8'h01, 8'h00, 1'b1);
    repeat (8)  cyc(8'h03, 8'h00, 1'b1);
    // lone clear, then clear coinciding with the rise of channel 0
    cyc(8'h03, 8'h01, 1'b1);
    repeat (2)  cyc(8'h03, 8'h00, 1'b1);
    repeat (8)  cyc(8'h02, 8'h00, 1'b1);
    repeat (5)  cyc(8'h03, 8'h00, 1'b1);
    cyc(8'h03, 8'h01, 1'b1);
    repeat (3)  cyc(8'h03, 8'h00, 1'b1);
    // channel 2 pulse with a clear between its edges
    repeat (10) cyc(8'h07, 8'h00, 1'b1);
    cyc(8'h07, 8'h04, 1'b1);
    repeat (10) cyc(8'h03, 8'h00, 1'b1);
    // reset in the middle of a count on channel 3
    repeat (4)  cyc(8'h0B, 8'h00, 1'b1);
    repeat (2)  cyc(8'h0B, 8'h00, 1'b0);
    repeat (10) cyc(8'h0B, 8'h00, 1'b1);
    // randomized run: sparse per-bit toggles give a spread of pulse lengths
    dr = 8'h0B;
    for (int n = 0; n < 3000; n++) begin
      dr ^= 8'($urandom & $urandom);
      cyc(dr, ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h00,
          ($urandom_range(0, 499) != 0));
    end
    repeat (3) cyc(dr, 8'h00, 1'b1);
    @(negedge clk);
    #2;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
